// File: rtl/sdram_arbiter.sv
// SDRAM sub-engine scheduler: owns the auto-refresh interval timer and grants
// the bus to one of init / refresh / write / read at a time. It also muxes the
// owner's command word onto the shared SDRAM command bus. Refresh is raised as
// a pending request; an active burst finishes at its boundary before refresh
// gets the bus. Write and read alternate when both are requesting.
module sdram_arbiter #(
    parameter int                 CMD_W      = 18,
    parameter logic [CMD_W-1:0]   CMD_NOP    = 18'b0111_00_000000000000,
    parameter int                 REF_PERIOD = 780,
    parameter int                 CNT_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic [CMD_W-1:0]  cmd_init,
    input  logic [CMD_W-1:0]  cmd_ref,
    input  logic [CMD_W-1:0]  cmd_wr,
    input  logic [CMD_W-1:0]  cmd_rd,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              ref_end,
    input  logic              wr_end,
    input  logic              rd_end,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              ref_break,
    output logic [CMD_W-1:0]  cmd,
    output logic              ref_miss
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(REF_PERIOD - 1);
    localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic               last_wr_q, last_wr_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               ref_pending_q, ref_pending_d;
    logic               ref_miss_q, ref_miss_d;
    logic               expire_s;
    logic               ref_done_s;

    // Refresh interval timer: idle until init completes, then free-running modulo REF_PERIOD.
    always_comb begin
        timer_d  = timer_q;
        expire_s = 1'b0;
        if (!init_done) begin
            timer_d = {CNT_W{1'b0}};
        end else if (timer_q == TMR_LAST) begin
            timer_d  = {CNT_W{1'b0}};
            expire_s = 1'b1;
        end else begin
            timer_d = timer_q + TMR_ONE;
        end
    end

    // Refresh bookkeeping: a new expiry always wins over a completing refresh on the same edge.
    always_comb begin
        ref_done_s    = (state_q == ST_AREF) && ref_end;
        ref_pending_d = ref_pending_q;
        ref_miss_d    = ref_miss_q;
        if (expire_s) begin
            ref_pending_d = 1'b1;
            if (ref_pending_q && !ref_done_s) begin
                ref_miss_d = 1'b1;
            end else begin
                ref_miss_d = ref_miss_q;
            end
        end else if (ref_done_s) begin
            ref_pending_d = 1'b0;
        end else begin
            ref_pending_d = ref_pending_q;
        end
    end

    // Next-state logic: refresh first, then round-robin between write and read.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            ST_INIT: begin
                if (init_done) begin
                    state_d = ST_ARBIT;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_ARBIT: begin
                if (ref_pending_q) begin
                    state_d = ST_AREF;
                end else if (wr_req && rd_req) begin
                    if (last_wr_q) begin
                        state_d   = ST_READ;
                        last_wr_d = 1'b0;
                    end else begin
                        state_d   = ST_WRITE;
                        last_wr_d = 1'b1;
                    end
                end else if (wr_req) begin
                    state_d   = ST_WRITE;
                    last_wr_d = 1'b1;
                end else if (rd_req) begin
                    state_d   = ST_READ;
                    last_wr_d = 1'b0;
                end else begin
                    state_d = ST_ARBIT;
                end
            end
            ST_AREF: begin
                if (ref_end) begin
                    state_d = ST_ARBIT;
                end else begin
                    state_d = ST_AREF;
                end
            end
            ST_WRITE: begin
                if (wr_end) begin
                    state_d = ST_ARBIT;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (rd_end) begin
                    state_d = ST_ARBIT;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State, timer and refresh flags register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            last_wr_q     <= 1'b0;
            timer_q       <= {CNT_W{1'b0}};
            ref_pending_q <= 1'b0;
            ref_miss_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_wr_q     <= last_wr_d;
            timer_q       <= timer_d;
            ref_pending_q <= ref_pending_d;
            ref_miss_q    <= ref_miss_d;
        end
    end

    // Command mux follows the state register directly so engine commands see no extra latency.
    always_comb begin
        cmd = CMD_NOP;
        case (state_q)
            ST_INIT:  cmd = cmd_init;
            ST_ARBIT: cmd = CMD_NOP;
            ST_AREF:  cmd = cmd_ref;
            ST_WRITE: cmd = cmd_wr;
            ST_READ:  cmd = cmd_rd;
            default:  cmd = CMD_NOP;
        endcase
    end

    assign ref_en    = (state_q == ST_AREF);
    assign wr_en     = (state_q == ST_WRITE);
    assign rd_en     = (state_q == ST_READ);
    assign ref_break = ref_pending_q;
    assign ref_miss  = ref_miss_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter: init hold, write/read alternation,
// refresh preemption at burst boundary, set-wins corner, sticky miss, reset.
module tb_sdram_arbiter;

    localparam logic [17:0] C_NOP  = 18'b0111_00_000000000000;
    localparam logic [17:0] C_INIT = 18'h12345;
    localparam logic [17:0] C_REF  = 18'h2abcd;
    localparam logic [17:0] C_WR   = 18'h0f0f0;
    localparam logic [17:0] C_RD   = 18'h3c3c3;

    logic        clk = 1'b0;
    logic        rst, init_done, wr_req, rd_req, ref_end, wr_end, rd_end;
    logic [17:0] cmd_init, cmd_ref, cmd_wr, cmd_rd;
    logic        ref_en, wr_en, rd_en, ref_break, ref_miss;
    logic [17:0] cmd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .cmd_init(cmd_init), .cmd_ref(cmd_ref), .cmd_wr(cmd_wr), .cmd_rd(cmd_rd),
        .wr_req(wr_req), .rd_req(rd_req),
        .ref_end(ref_end), .wr_end(wr_end), .rd_end(rd_end),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
        .ref_break(ref_break), .cmd(cmd), .ref_miss(ref_miss)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    // One granted burst of 'hold' cycles for engine eng (0 = write, 1 = read).
    task automatic do_grant(input int eng, input int hold);
        tick();
        check_val("grant_wr", {31'd0, wr_en}, (eng == 0) ? 32'd1 : 32'd0);
        check_val("grant_rd", {31'd0, rd_en}, (eng == 1) ? 32'd1 : 32'd0);
        check_val("grant_cmd", {14'd0, cmd}, (eng == 0) ? {14'd0, C_WR} : {14'd0, C_RD});
        for (int i = 1; i < hold; i++) begin
            if (i == 2) begin
                if (eng == 0) rd_end = 1'b1; else wr_end = 1'b1;
            end
            tick();
            rd_end = 1'b0;
            wr_end = 1'b0;
            check_val("hold_en", {31'd0, (eng == 0) ? wr_en : rd_en}, 32'd1);
        end
        if (eng == 0) wr_end = 1'b1; else rd_end = 1'b1;
        tick();
        wr_end = 1'b0;
        rd_end = 1'b0;
        check_val("end_wr", {31'd0, wr_en}, 32'd0);
        check_val("end_rd", {31'd0, rd_en}, 32'd0);
        check_val("end_nop", {14'd0, cmd}, {14'd0, C_NOP});
    endtask

    initial begin
        cmd_init = C_INIT; cmd_ref = C_REF; cmd_wr = C_WR; cmd_rd = C_RD;
        rst = 1'b1; init_done = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0;
        ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_val("rst_cmd", {14'd0, cmd}, {14'd0, C_INIT});
        check_val("rst_grants", {29'd0, ref_en, wr_en, rd_en}, 32'd0);
        check_val("rst_break", {31'd0, ref_break}, 32'd0);
        check_val("rst_miss", {31'd0, ref_miss}, 32'd0);
        repeat (100) tick();
        check_val("init_cmd", {14'd0, cmd}, {14'd0, C_INIT});
        check_val("init_grants", {29'd0, ref_en, wr_en, rd_en}, 32'd0);

        // Timer starts from 0 when init_done rises.
        init_done = 1'b1;
        cyc = 0;
        tick();
        check_val("arbit_nop", {14'd0, cmd}, {14'd0, C_NOP});

        // Alternation from reset: write first.
        wr_req = 1'b1; rd_req = 1'b1;
        do_grant(0, 8);
        do_grant(1, 8);
        do_grant(0, 8);
        do_grant(1, 8);
        // Single requester bursts.
        rd_req = 1'b0;
        do_grant(0, 3);
        wr_req = 1'b0; rd_req = 1'b1;
        do_grant(1, 3);
        rd_req = 1'b0;

        // Refresh request arrives mid-write.
        tick_to(770);
        check_val("idle_nop", {14'd0, cmd}, {14'd0, C_NOP});
        wr_req = 1'b1;
        tick();
        check_val("w4_wr_en", {31'd0, wr_en}, 32'd1);
        tick_to(779);
        check_val("brk_779", {31'd0, ref_break}, 32'd0);
        tick();
        check_val("brk_780", {31'd0, ref_break}, 32'd1);
        check_val("no_preempt", {31'd0, wr_en}, 32'd1);
        rd_req = 1'b1; wr_req = 1'b0; wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        check_val("w4_arbit", {14'd0, cmd}, {14'd0, C_NOP});
        tick();
        check_val("aref_en", {31'd0, ref_en}, 32'd1);
        check_val("aref_rd", {31'd0, rd_en}, 32'd0);
        check_val("aref_cmd", {14'd0, cmd}, {14'd0, C_REF});
        ref_end = 1'b1;
        tick();
        ref_end = 1'b0;
        check_val("aref_done", {31'd0, ref_en}, 32'd0);
        check_val("brk_clr", {31'd0, ref_break}, 32'd0);
        tick();
        check_val("rd_after_ref", {31'd0, rd_en}, 32'd1);
        rd_req = 1'b0; rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        check_val("rd_done", {31'd0, rd_en}, 32'd0);

        // ref_end on the same edge as the next expiry: pending stays, no miss.
        tick_to(1559);
        check_val("brk_1559", {31'd0, ref_break}, 32'd0);
        tick();
        check_val("brk_1560", {31'd0, ref_break}, 32'd1);
        tick();
        check_val("aref2_en", {31'd0, ref_en}, 32'd1);
        tick_to(2339);
        ref_end = 1'b1;
        tick();
        ref_end = 1'b0;
        check_val("setwin_en", {31'd0, ref_en}, 32'd0);
        check_val("setwin_brk", {31'd0, ref_break}, 32'd1);
        check_val("setwin_miss", {31'd0, ref_miss}, 32'd0);
        tick();
        check_val("aref3_en", {31'd0, ref_en}, 32'd1);

        // Refresh never finishes before the next expiry: sticky miss.
        tick_to(3119);
        check_val("miss_3119", {31'd0, ref_miss}, 32'd0);
        tick();
        check_val("miss_3120", {31'd0, ref_miss}, 32'd1);
        ref_end = 1'b1;
        tick();
        ref_end = 1'b0;
        check_val("miss_brk_clr", {31'd0, ref_break}, 32'd0);
        check_val("miss_ref_en", {31'd0, ref_en}, 32'd0);
        tick();
        check_val("miss_sticky", {31'd0, ref_miss}, 32'd1);

        // Reset in the middle of a read.
        rd_req = 1'b1;
        tick();
        check_val("r6_rd_en", {31'd0, rd_en}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_req = 1'b0;
        cyc = 0;
        check_val("r6_rd_off", {31'd0, rd_en}, 32'd0);
        check_val("r6_cmd", {14'd0, cmd}, {14'd0, C_INIT});
        check_val("r6_brk", {31'd0, ref_break}, 32'd0);
        check_val("r6_miss", {31'd0, ref_miss}, 32'd0);
        tick();
        check_val("r6_arbit", {14'd0, cmd}, {14'd0, C_NOP});
        tick_to(779);
        check_val("r6_brk_779", {31'd0, ref_break}, 32'd0);
        tick();
        check_val("r6_brk_780", {31'd0, ref_break}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
